// File: rtl/boot_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : boot_pkg
// Purpose  : Shared state encoding and frame constants for the boot image sender.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package boot_pkg;

    typedef logic [2:0] boot_state_t;

    localparam boot_state_t c_ST_IDLE   = 3'd0;
    localparam boot_state_t c_ST_HDR_LO = 3'd1;
    localparam boot_state_t c_ST_HDR_HI = 3'd2;
    localparam boot_state_t c_ST_DATA   = 3'd3;
    localparam boot_state_t c_ST_GAP    = 3'd4;
    localparam boot_state_t c_ST_FIN    = 3'd5;

    // Load address the boot ROM copies the image to.
    localparam logic [31:0] BOOT_BASE_ADDR = 32'h1000_0000;
    localparam int          FRAME_BITS     = 10;

endpackage
`default_nettype wire

// File: rtl/uart_tx_8n1.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_tx_8n1
// Purpose  : 8N1 serializer; accepts the next byte on the final cycle of a stop bit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_tx_8n1
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 432
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int                 c_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]         c_BIT_LAST = 4'(FRAME_BITS - 1);

    logic                  r_active;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [3:0]            r_bit;
    logic [FRAME_BITS-1:0] r_shift;

    logic w_bit_end;
    logic w_frame_end;

    assign w_bit_end   = (r_cnt == c_CNT_LAST);
    assign w_frame_end = r_active && w_bit_end && (r_bit == c_BIT_LAST);
    assign ready       = !r_active || w_frame_end;
    // Ones are shifted in behind the frame so the line rests at mark.
    assign tx          = r_shift[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '1;
        end else if (valid && ready) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= {1'b1, data, 1'b0};
        end else if (r_active) begin
            if (w_bit_end) begin
                r_cnt   <= '0;
                r_shift <= {1'b1, r_shift[FRAME_BITS-1:1]};
                if (r_bit == c_BIT_LAST) begin
                    r_active <= 1'b0;
                    r_bit    <= '0;
                end else begin
                    r_bit <= r_bit + 4'd1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/boot_image_tx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : boot_image_tx
// Purpose  : Streams a length header plus image bytes to the UART bootloader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module boot_image_tx
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 432,
    parameter int GAP_BITS     = 0,
    parameter int AW           = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_data,
    output logic          tx,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int                 c_GAP_CYC  = GAP_BITS * CLKS_PER_BIT;
    localparam int                 c_GAP_W    = (c_GAP_CYC > 1) ? $clog2(c_GAP_CYC) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((c_GAP_CYC > 0) ? (c_GAP_CYC - 1) : 0);
    localparam bit                 c_HAS_GAP  = (GAP_BITS > 0);

    boot_state_t        r_state;
    boot_state_t        r_after;
    logic [AW-1:0]      r_len;
    logic [AW-1:0]      r_remain;
    logic [AW-1:0]      r_addr;
    logic [7:0]         r_hold;
    logic               r_mem_rd;
    logic               r_rd_q;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic        w_ready;
    logic        w_valid;
    logic [7:0]  w_data;
    logic [7:0]  w_len_hi;
    logic        w_len_ok;
    logic        w_accept;
    logic        w_frame_end;
    logic        w_gap_end;
    logic        w_go;
    boot_state_t w_next;
    boot_state_t w_kind;

    // A zero low byte would look like "no length yet" to the boot ROM.
    assign w_len_ok    = (len != '0) && (len[7:0] != 8'h00);
    assign w_accept    = (r_state == c_ST_IDLE) && start && w_len_ok && w_ready;
    assign w_len_hi    = 8'(r_len >> 8);
    assign w_frame_end = w_ready && ((r_state == c_ST_HDR_LO) ||
                                     (r_state == c_ST_HDR_HI) ||
                                     (r_state == c_ST_DATA));
    assign w_gap_end   = (r_state == c_ST_GAP) && (r_gap_cnt == c_GAP_LAST);
    assign w_go        = w_gap_end || (w_frame_end && !c_HAS_GAP);
    assign w_kind      = (r_state == c_ST_GAP) ? r_after : w_next;

    always_comb begin
        w_next = c_ST_FIN;
        case (r_state)
            c_ST_HDR_LO: w_next = c_ST_HDR_HI;
            c_ST_HDR_HI: w_next = c_ST_DATA;
            default:     w_next = (r_remain == '0) ? c_ST_FIN : c_ST_DATA;
        endcase
    end

    always_comb begin
        w_valid = 1'b0;
        w_data  = len[7:0];
        if (w_accept) begin
            w_valid = 1'b1;
            w_data  = len[7:0];
        end else if (w_go && (w_kind == c_ST_HDR_HI)) begin
            w_valid = 1'b1;
            w_data  = w_len_hi;
        end else if (w_go && (w_kind == c_ST_DATA)) begin
            w_valid = 1'b1;
            w_data  = r_hold;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_ST_IDLE;
            r_after   <= c_ST_IDLE;
            r_len     <= '0;
            r_remain  <= '0;
            r_addr    <= '0;
            r_hold    <= '0;
            r_mem_rd  <= 1'b0;
            r_rd_q    <= 1'b0;
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_mem_rd <= 1'b0;
            r_rd_q   <= r_mem_rd;
            if (r_rd_q) begin
                r_hold <= mem_data;
            end
            if (r_mem_rd && (r_addr != (r_len - AW'(1)))) begin
                r_addr <= r_addr + AW'(1);
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (start && !w_len_ok) begin
                        r_err <= 1'b1;
                    end else if (w_accept) begin
                        r_len    <= len;
                        r_remain <= len;
                        r_addr   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= c_ST_HDR_LO;
                    end
                end
                c_ST_HDR_LO, c_ST_HDR_HI, c_ST_DATA: begin
                    if (w_frame_end && c_HAS_GAP) begin
                        r_state   <= c_ST_GAP;
                        r_after   <= w_next;
                        r_gap_cnt <= '0;
                    end
                end
                c_ST_GAP: r_gap_cnt <= r_gap_cnt + 1'b1;
                default:  r_state   <= c_ST_IDLE;
            endcase

            // Launching the next item overrides the per-state bookkeeping above.
            if (w_go) begin
                case (w_kind)
                    c_ST_HDR_HI: begin
                        r_state  <= c_ST_HDR_HI;
                        r_mem_rd <= 1'b1;
                    end
                    c_ST_DATA: begin
                        r_state  <= c_ST_DATA;
                        r_remain <= r_remain - AW'(1);
                        if (r_remain > AW'(1)) begin
                            r_mem_rd <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= c_ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                endcase
            end
        end
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk    (clk),
        .reset_n(reset_n),
        .data   (w_data),
        .valid  (w_valid),
        .ready  (w_ready),
        .tx     (tx)
    );

    assign mem_addr = r_addr;
    assign mem_rd   = r_mem_rd;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire
